// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding, forwarding select codes and the forwarding priority helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2,
    LD_STALL = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;  // operand from register file
  localparam logic [1:0] FWD_MEM = 2'd1;  // operand from M-stage result
  localparam logic [1:0] FWD_WB  = 2'd2;  // operand from W-stage result

  // The younger M-stage result wins over the W-stage result.
  function automatic logic [1:0] fwd_pick(input logic m_hit, input logic w_hit);
    if (m_hit) begin
      return FWD_MEM;
    end else if (w_hit) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-stage fields consumed by the hazard controller and
// the stall/flush/forwarding controls it returns. master = pipeline side,
// slave = controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] d_rs1;
  logic [REG_ADDR_W-1:0] d_rs2;
  logic                  d_uses_rs1;
  logic                  d_uses_rs2;
  logic [REG_ADDR_W-1:0] e_rs1;
  logic [REG_ADDR_W-1:0] e_rs2;
  logic [REG_ADDR_W-1:0] e_rd;
  logic                  e_reg_write;
  logic                  e_is_load;
  logic                  e_redirect;
  logic [REG_ADDR_W-1:0] m_rd;
  logic                  m_reg_write;
  logic [REG_ADDR_W-1:0] w_rd;
  logic                  w_reg_write;
  logic                  dmem_req;
  logic                  dmem_ready;

  logic                  pc_write_en;
  logic                  fd_write_en;
  logic                  fd_flush;
  logic                  de_flush;
  logic                  pipe_hold;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic [31:0]           stall_count;
  logic [31:0]           flush_count;

  modport master (
    output d_rs1, d_rs2, d_uses_rs1, d_uses_rs2,
    output e_rs1, e_rs2, e_rd, e_reg_write, e_is_load, e_redirect,
    output m_rd, m_reg_write, w_rd, w_reg_write, dmem_req, dmem_ready,
    input  pc_write_en, fd_write_en, fd_flush, de_flush, pipe_hold,
    input  fwd_a_sel, fwd_b_sel, stall_count, flush_count
  );

  modport slave (
    input  d_rs1, d_rs2, d_uses_rs1, d_uses_rs2,
    input  e_rs1, e_rs2, e_rd, e_reg_write, e_is_load, e_redirect,
    input  m_rd, m_reg_write, w_rd, w_reg_write, dmem_req, dmem_ready,
    output pc_write_en, fd_write_en, fd_flush, de_flush, pipe_hold,
    output fwd_a_sel, fwd_b_sel, stall_count, flush_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Combinational forwarding select for one execute-stage source operand.
// x0 is never forwarded; the M stage has priority over the W stage.
module forward_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] e_rs,
  input  logic [REG_ADDR_W-1:0] m_rd,
  input  logic                  m_reg_write,
  input  logic [REG_ADDR_W-1:0] w_rd,
  input  logic                  w_reg_write,
  output logic [1:0]            sel
);

  logic m_hit;
  logic w_hit;

  // Match the operand against each older in-flight writer.
  always_comb begin
    m_hit = m_reg_write && (m_rd != '0) && (m_rd == e_rs);
    w_hit = w_reg_write && (w_rd != '0) && (w_rd == e_rs);
    sel   = fwd_pick(m_hit, w_hit);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes, data
// memory wait holds and operand forwarding selects.
// Optional macro HAZARD_PERF_EN adds 32-bit stall/flush performance counters;
// without it the counter ports read 0 and no counter flops exist.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,  // 1..7
  parameter int REG_ADDR_W   = 5
) (
  input logic                   clock,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave bus
);

  state_t     state_reg;
  state_t     state_next;
  logic [2:0] count_reg;   // remaining REDIRECT cycles; 0 when no redirect pending
  logic [2:0] count_next;

  logic pc_write_en;
  logic fd_write_en;
  logic fd_flush;
  logic de_flush;
  logic pipe_hold;
  logic mem_wait;
  logic load_use;
  logic in_redirect;

  logic [REG_ADDR_W-1:0] e_rs    [2];
  logic [1:0]            fwd_sel [2];

  // Hazard terms from the current pipeline contents.
  always_comb begin
    mem_wait = bus.dmem_req && !bus.dmem_ready;
    load_use = bus.e_is_load && bus.e_reg_write && (bus.e_rd != '0) &&
               ((bus.d_uses_rs1 && (bus.d_rs1 == bus.e_rd)) ||
                (bus.d_uses_rs2 && (bus.d_rs2 == bus.e_rd)));
    // A wait that interrupted a redirect resumes flushing once released,
    // which the frozen non-zero count remembers.
    in_redirect = (state_reg == REDIRECT) ||
                  ((state_reg == MEM_WAIT) && (count_reg != 3'd0));
  end

  // Next state and control outputs; mem-wait beats redirect beats load-use.
  always_comb begin
    pc_write_en = 1'b1;
    fd_write_en = 1'b1;
    fd_flush    = 1'b0;
    de_flush    = 1'b0;
    pipe_hold   = 1'b0;
    state_next  = state_reg;
    count_next  = count_reg;
    if (reset) begin
      pc_write_en = 1'b0;
      fd_write_en = 1'b0;
      fd_flush    = 1'b1;
      de_flush    = 1'b1;
      state_next  = RUN;
      count_next  = 3'd0;
    end else if (mem_wait) begin
      // Freeze everything; the redirect count (if any) is held.
      pc_write_en = 1'b0;
      fd_write_en = 1'b0;
      pipe_hold   = 1'b1;
      state_next  = MEM_WAIT;
    end else if (in_redirect) begin
      fd_flush = 1'b1;
      de_flush = 1'b1;
      if (count_reg <= 3'd1) begin
        state_next = RUN;
        count_next = 3'd0;
      end else begin
        state_next = REDIRECT;
        count_next = count_reg - 3'd1;
      end
    end else if (bus.e_redirect) begin
      // PC takes the target this cycle while younger instructions die.
      fd_flush = 1'b1;
      de_flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_next = REDIRECT;
        count_next = 3'(FLUSH_CYCLES - 1);
      end else begin
        state_next = RUN;
      end
    end else if (load_use) begin
      pc_write_en = 1'b0;
      fd_write_en = 1'b0;
      de_flush    = 1'b1;
      state_next  = LD_STALL;
    end else begin
      state_next = RUN;
    end
  end

  // State and redirect count registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
      count_reg <= 3'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  assign e_rs[0] = bus.e_rs1;
  assign e_rs[1] = bus.e_rs2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    forward_unit #(
      .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd (
      .e_rs        (e_rs[gi]),
      .m_rd        (bus.m_rd),
      .m_reg_write (bus.m_reg_write),
      .w_rd        (bus.w_rd),
      .w_reg_write (bus.w_reg_write),
      .sel         (fwd_sel[gi])
    );
  end

  assign bus.pc_write_en = pc_write_en;
  assign bus.fd_write_en = fd_write_en;
  assign bus.fd_flush    = fd_flush;
  assign bus.de_flush    = de_flush;
  assign bus.pipe_hold   = pipe_hold;
  assign bus.fwd_a_sel   = reset ? FWD_RF : fwd_sel[0];
  assign bus.fwd_b_sel   = reset ? FWD_RF : fwd_sel[1];

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count_reg;
  logic [31:0] flush_count_reg;

  // Count stalled and bubbled cycles; wraps naturally at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count_reg <= 32'd0;
      flush_count_reg <= 32'd0;
    end else begin
      if (!pc_write_en) stall_count_reg <= stall_count_reg + 32'd1;
      if (de_flush)     flush_count_reg <= flush_count_reg + 32'd1;
    end
  end

  assign bus.stall_count = stall_count_reg;
  assign bus.flush_count = flush_count_reg;
`else
  assign bus.stall_count = 32'd0;
  assign bus.flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2). Stimulus pushes
// the hand-computed expected controls per cycle; a negedge monitor pops
// and compares. Counter expectations follow HAZARD_PERF_EN.
module tb_pipeline_hazard_ctrl;

  logic clock;
  logic reset;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) bus ();

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES (2),
    .REG_ADDR_W   (5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       nm;
    logic [8:0]  ctl;  // {pc,fd,fd_flush,de_flush,hold,fwd_a,fwd_b}
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   run_stall = 0;
  int   run_flush = 0;

  // Monitor: one comparison per issued cycle.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t       e;
      logic [8:0] act;
      e   = q.pop_front();
      act = {bus.pc_write_en, bus.fd_write_en, bus.fd_flush, bus.de_flush,
             bus.pipe_hold, bus.fwd_a_sel, bus.fwd_b_sel};
      total++;
      if (act !== e.ctl || bus.stall_count !== e.sc || bus.flush_count !== e.fc) begin
        bad++;
        $display("FAIL %s: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                 e.nm, act, bus.stall_count, bus.flush_count, e.ctl, e.sc, e.fc);
      end else begin
        $display("ok   %s: ctl=%b stall=%0d flush=%0d", e.nm, act,
                 bus.stall_count, bus.flush_count);
      end
    end
  end

  task automatic idle();
    bus.d_rs1 = '0; bus.d_rs2 = '0; bus.d_uses_rs1 = 0; bus.d_uses_rs2 = 0;
    bus.e_rs1 = '0; bus.e_rs2 = '0; bus.e_rd = '0;
    bus.e_reg_write = 0; bus.e_is_load = 0; bus.e_redirect = 0;
    bus.m_rd = '0; bus.m_reg_write = 0; bus.w_rd = '0; bus.w_reg_write = 0;
    bus.dmem_req = 0; bus.dmem_ready = 1;
  endtask

  // Issue one cycle with the inputs already driven; push its expectation.
  task automatic vec(input string nm, input bit pc, input bit fd, input bit ff,
                     input bit df, input bit hd, input logic [1:0] fa,
                     input logic [1:0] fb);
    exp_t e;
    e.nm  = nm;
    e.ctl = {pc, fd, ff, df, hd, fa, fb};
    if (reset) begin
      run_stall = 0;
      run_flush = 0;
    end
`ifdef HAZARD_PERF_EN
    e.sc = 32'(run_stall);
    e.fc = 32'(run_flush);
`else
    e.sc = 32'd0;
    e.fc = 32'd0;
`endif
    q.push_back(e);
    if (!reset) begin
      run_stall += (pc ? 0 : 1);
      run_flush += (df ? 1 : 0);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(posedge clock);
    #1;
    bus.e_rs1 = 5'd7; bus.m_rd = 5'd7; bus.m_reg_write = 1;
    vec("reset_a", 0, 0, 1, 1, 0, 0, 0);
    idle();
    vec("reset_b", 0, 0, 1, 1, 0, 0, 0);
    reset = 1'b0;
    vec("run_idle", 1, 1, 0, 0, 0, 0, 0);

    // Load-use hazards
    bus.e_is_load = 1; bus.e_reg_write = 1; bus.e_rd = 5'd5;
    bus.d_rs1 = 5'd5; bus.d_uses_rs1 = 1;
    vec("ld_use_rs1", 0, 0, 0, 1, 0, 0, 0);
    idle();
    vec("ld_stall_next", 1, 1, 0, 0, 0, 0, 0);
    bus.e_is_load = 1; bus.e_reg_write = 1; bus.e_rd = 5'd0;
    bus.d_rs1 = 5'd0; bus.d_uses_rs1 = 1;
    vec("ld_to_x0", 1, 1, 0, 0, 0, 0, 0);
    bus.e_rd = 5'd5; bus.d_rs1 = 5'd5; bus.d_uses_rs1 = 0;
    vec("ld_rs1_unused", 1, 1, 0, 0, 0, 0, 0);
    bus.d_rs2 = 5'd5; bus.d_uses_rs2 = 1;
    vec("ld_use_rs2", 0, 0, 0, 1, 0, 0, 0);
    idle();
    vec("run_after_rs2", 1, 1, 0, 0, 0, 0, 0);
    bus.e_reg_write = 1; bus.e_rd = 5'd5; bus.d_rs1 = 5'd5; bus.d_uses_rs1 = 1;
    vec("alu_no_stall", 1, 1, 0, 0, 0, 0, 0);

    // Redirect, two flush cycles
    idle(); bus.e_redirect = 1;
    vec("redir_0", 1, 1, 1, 1, 0, 0, 0);
    idle();
    vec("redir_1", 1, 1, 1, 1, 0, 0, 0);
    vec("redir_done", 1, 1, 0, 0, 0, 0, 0);

    // Data memory wait for three cycles
    bus.dmem_req = 1; bus.dmem_ready = 0;
    for (int i = 0; i < 3; i++) vec($sformatf("mem_wait_%0d", i), 0, 0, 0, 0, 1, 0, 0);
    bus.dmem_ready = 1;
    vec("mem_ready", 1, 1, 0, 0, 0, 0, 0);
    idle();
    vec("mem_after", 1, 1, 0, 0, 0, 0, 0);

    // Wait and redirect together: hold first, flush after release
    bus.dmem_req = 1; bus.dmem_ready = 0; bus.e_redirect = 1;
    vec("sim_hold_0", 0, 0, 0, 0, 1, 0, 0);
    vec("sim_hold_1", 0, 0, 0, 0, 1, 0, 0);
    bus.dmem_ready = 1;
    vec("sim_release", 1, 1, 1, 1, 0, 0, 0);
    idle();
    vec("sim_redir_tail", 1, 1, 1, 1, 0, 0, 0);
    vec("sim_done", 1, 1, 0, 0, 0, 0, 0);

    // Wait arriving inside REDIRECT freezes and then resumes it
    bus.e_redirect = 1;
    vec("nest_redir_0", 1, 1, 1, 1, 0, 0, 0);
    idle(); bus.dmem_req = 1; bus.dmem_ready = 0;
    vec("nest_hold_0", 0, 0, 0, 0, 1, 0, 0);
    vec("nest_hold_1", 0, 0, 0, 0, 1, 0, 0);
    bus.dmem_ready = 1;
    vec("nest_resume", 1, 1, 1, 1, 0, 0, 0);
    idle();
    vec("nest_done", 1, 1, 0, 0, 0, 0, 0);

    // Forwarding selects
    bus.e_rs1 = 5'd7; bus.m_rd = 5'd7; bus.w_rd = 5'd7;
    bus.m_reg_write = 1; bus.w_reg_write = 1;
    vec("fwd_a_mem", 1, 1, 0, 0, 0, 1, 0);
    bus.e_rs2 = 5'd7;
    vec("fwd_ab_mem", 1, 1, 0, 0, 0, 1, 1);
    bus.m_reg_write = 0;
    vec("fwd_ab_wb", 1, 1, 0, 0, 0, 2, 2);
    bus.m_reg_write = 1; bus.m_rd = 5'd3;
    vec("fwd_m_other", 1, 1, 0, 0, 0, 2, 2);
    bus.e_rs1 = 5'd0; bus.e_rs2 = 5'd0; bus.m_rd = 5'd0; bus.w_rd = 5'd0;
    vec("fwd_x0", 1, 1, 0, 0, 0, 0, 0);
    bus.e_rs2 = 5'd9; bus.w_rd = 5'd9; bus.m_rd = 5'd3;
    vec("fwd_b_wb", 1, 1, 0, 0, 0, 0, 2);
    bus.w_reg_write = 0;
    vec("fwd_b_nowrite", 1, 1, 0, 0, 0, 0, 0);
    idle();
    bus.e_rs1 = 5'd7; bus.m_rd = 5'd7; bus.m_reg_write = 1;
    bus.dmem_req = 1; bus.dmem_ready = 0;
    vec("fwd_in_wait", 0, 0, 0, 0, 1, 1, 0);
    idle();
    vec("fwd_wait_done", 1, 1, 0, 0, 0, 0, 0);

    // Reset in the middle of a redirect
    bus.e_redirect = 1;
    vec("rst_redir_0", 1, 1, 1, 1, 0, 0, 0);
    idle();
    reset = 1'b1;
    vec("rst_mid", 0, 0, 1, 1, 0, 0, 0);
    reset = 1'b0;
    vec("rst_after", 1, 1, 0, 0, 0, 0, 0);
    vec("rst_after_2", 1, 1, 0, 0, 0, 0, 0);

    // Every issued cycle must have been checked by now.
    @(negedge clock);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
